// File: rtl/pipe_csel_adder_pkg.sv
// csa_pkg: shared constants and types for the pipelined carry-select adder.
//   CSA_WIDTH_DEF / CSA_BLK_DEF : default operand width and block width
//   nstg()                      : number of pipeline stages for a geometry
//   csa_stage_t                 : stage-register layout at the default width
package csa_pkg;

  localparam int CSA_WIDTH_DEF = 16;
  localparam int CSA_BLK_DEF   = 4;

  // A zero block width is rejected at elaboration by the top; return one
  // stage here so the division never sees zero.
  function automatic int nstg(input int width, input int blk);
    if (blk > 0) begin
      return width / blk;
    end else begin
      return 1;
    end
  endfunction

  // One pipeline slot: valid flag, sum bits completed so far, carry into
  // the next block, and the operands still being consumed.
  typedef struct packed {
    logic                     vld;
    logic [CSA_WIDTH_DEF-1:0] lo;
    logic                     carry;
    logic [CSA_WIDTH_DEF-1:0] a;
    logic [CSA_WIDTH_DEF-1:0] b;
  } csa_stage_t;

endpackage

// File: rtl/pipe_csel_adder_csel_block.sv
// csel_block: combinational BLK-bit carry-select unit.
//   a, b      : in  BLK bits, operand slices
//   carry_in  : in  1 bit, selects the precomputed result
//   sum       : out BLK bits
//   carry_out : out 1 bit
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           carry_in,
  output logic [BLK-1:0] sum,
  output logic           carry_out
);

  logic [BLK:0] sum0_s;
  logic [BLK:0] sum1_s;

  // Both adders resolve before the carry arrives; the carry only drives a mux.
  always_comb begin
    sum0_s = {1'b0, a} + {1'b0, b};
    sum1_s = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    if (carry_in) begin
      {carry_out, sum} = sum1_s;
    end else begin
      {carry_out, sum} = sum0_s;
    end
  end

endmodule

// File: rtl/pipe_csel_adder.sv
// pipe_csel_adder: pipelined carry-select adder, one BLK-bit block per stage,
// valid/ready handshake, {cout,sum} = a + b + cin.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = out_ready | ~out_valid)
//   a, b, cin           : operands and carry in
//   out_valid/out_ready : result handshake
//   sum, cout           : registered result
//   ovf                 : registered signed overflow, only when CSA_OVF_EN is defined
// Latency is WIDTH/BLK cycles; the whole pipeline stalls as one unit.
module pipe_csel_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int BLK   = CSA_BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = nstg(WIDTH, BLK);
  localparam int MSB  = WIDTH - 1;

  // Same layout as csa_stage_t, sized for this instance's width.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] lo;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if (BLK < 1) begin : g_bad_blk
    $error("pipe_csel_adder: BLK must be at least 1");
  end else if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("pipe_csel_adder: WIDTH must be a multiple of BLK");
  end

  // The pipeline advances whenever the output slot is empty or being taken.
  logic en_s;
  assign en_s     = out_ready | ~out_valid;
  assign in_ready = en_s;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stage_t         src_s;
    stage_t         nxt_s;
    stage_t         stg_r;
    logic [BLK-1:0] blk_sum_s;
    logic           blk_co_s;

    if (k == 0) begin : g_head
      assign src_s = '{vld: in_valid, lo: {WIDTH{1'b0}}, carry: cin, a: a, b: b};
    end else begin : g_body
      assign src_s = g_stg[k-1].stg_r;
    end

    csel_block #(
      .BLK(BLK)
    ) u_blk (
      .a        (src_s.a[k*BLK +: BLK]),
      .b        (src_s.b[k*BLK +: BLK]),
      .carry_in (src_s.carry),
      .sum      (blk_sum_s),
      .carry_out(blk_co_s)
    );

    // Merge this stage's block result into the travelling slot.
    always_comb begin
      nxt_s                  = src_s;
      nxt_s.lo[k*BLK +: BLK] = blk_sum_s;
      nxt_s.carry            = blk_co_s;
    end

    // Stage register; holds in place during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_r <= '0;
      end else if (en_s) begin
        stg_r <= nxt_s;
      end else begin
        stg_r <= stg_r;
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].stg_r.vld;
  assign sum       = g_stg[NSTG-1].stg_r.lo;
  assign cout      = g_stg[NSTG-1].stg_r.carry;

`ifdef CSA_OVF_EN
  logic ovf_nxt_s;
  logic ovf_r;

  // Overflow: like-signed operands producing a result of the other sign.
  always_comb begin
    ovf_nxt_s = (g_stg[NSTG-1].src_s.a[MSB] == g_stg[NSTG-1].src_s.b[MSB]) &
                (g_stg[NSTG-1].nxt_s.lo[MSB] != g_stg[NSTG-1].src_s.a[MSB]);
  end

  // Overflow register moves with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en_s) begin
      ovf_r <= ovf_nxt_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  // Operand copies in the last slot are fully consumed.
  logic unused_s;
  assign unused_s = ^{g_stg[NSTG-1].stg_r.a, g_stg[NSTG-1].stg_r.b, MSB[0]};

endmodule
